// File: rtl/arb_in_fifo_pkg.sv
// Shared arbiter definitions: default data width, channel count and channel indices.
package arb_in_fifo_pkg;

    localparam int ARB_WIDTH     = 64;
    localparam int ARB_NUM_CH    = 3;
    localparam int ARB_DEF_DEPTH = 4;
    localparam int ARB_DEF_AFULL = 3;

    typedef enum logic [1:0] {
        CH_A = 2'd0,
        CH_B = 2'd1,
        CH_C = 2'd2
    } arb_ch_e;

endpackage

// File: rtl/arb_fifo_mem.sv
// DEPTH x WIDTH flop storage with one write port and one asynchronous read port.
module arb_fifo_mem
    import arb_in_fifo_pkg::*;
#(
    parameter int WIDTH = ARB_WIDTH,
    parameter int DEPTH = ARB_DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             ASynReset_N,
    input  logic             i_WrEn,
    input  logic [AW-1:0]    i_WrAddr,
    input  logic [WIDTH-1:0] i_WrData,
    input  logic [AW-1:0]    i_RdAddr,
    output logic [WIDTH-1:0] o_RdData
);

    logic [WIDTH-1:0] r_Mem [DEPTH];

    // Reset clears every entry so the head word reads as zero out of reset.
    always_ff @(posedge CLK or negedge ASynReset_N) begin
        if (!ASynReset_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_Mem[i] <= '0;
            end
        end else if (i_WrEn) begin
            r_Mem[i_WrAddr] <= i_WrData;
        end
    end

    assign o_RdData = r_Mem[i_RdAddr];

endmodule

// File: rtl/arb_in_fifo.sv
// First-word-fall-through input buffer sitting in front of one arbiter channel.
module arb_in_fifo
    import arb_in_fifo_pkg::*;
#(
    parameter int WIDTH    = ARB_WIDTH,
    parameter int DEPTH    = ARB_DEF_DEPTH,
    parameter int AFULL_TH = ARB_DEF_AFULL
) (
    input  logic                     CLK,
    input  logic                     ASynReset_N,
    input  logic                     i_Flush,
    input  logic                     i_WrValid,
    input  logic [WIDTH-1:0]         i_WrData,
    output logic                     o_WrReady,
    output logic                     o_DataValid,
    output logic [WIDTH-1:0]         o_DataOut,
    input  logic                     i_DataGrant,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic                     o_AFull
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] LP_AFULL = CW'(AFULL_TH);

    logic [AW-1:0] r_WrPtr;
    logic [AW-1:0] r_RdPtr;
    logic [CW-1:0] r_Count;
    logic          w_Wr;
    logic          w_Rd;
    logic          w_MemWrEn;

    // Flags come only from the count register, so ready never depends on the grant.
    assign o_Full      = (r_Count == LP_DEPTH);
    assign o_Empty     = (r_Count == '0);
    assign o_AFull     = (r_Count >= LP_AFULL);
    assign o_WrReady   = !o_Full;
    assign o_DataValid = !o_Empty;
    assign o_Count     = r_Count;

    assign w_Wr      = i_WrValid & o_WrReady;
    assign w_Rd      = o_DataValid & i_DataGrant;
    assign w_MemWrEn = w_Wr & !i_Flush;

    // Flush rewinds pointers and count but leaves storage untouched.
    always_ff @(posedge CLK or negedge ASynReset_N) begin
        if (!ASynReset_N) begin
            r_WrPtr <= '0;
            r_RdPtr <= '0;
            r_Count <= '0;
        end else if (i_Flush) begin
            r_WrPtr <= '0;
            r_RdPtr <= '0;
            r_Count <= '0;
        end else begin
            if (w_Wr) begin
                r_WrPtr <= r_WrPtr + 1'b1;
            end
            if (w_Rd) begin
                r_RdPtr <= r_RdPtr + 1'b1;
            end
            if (w_Wr && !w_Rd) begin
                r_Count <= r_Count + 1'b1;
            end else if (!w_Wr && w_Rd) begin
                r_Count <= r_Count - 1'b1;
            end
        end
    end

    arb_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .CLK         (CLK),
        .ASynReset_N (ASynReset_N),
        .i_WrEn      (w_MemWrEn),
        .i_WrAddr    (r_WrPtr),
        .i_WrData    (i_WrData),
        .i_RdAddr    (r_RdPtr),
        .o_RdData    (o_DataOut)
    );

endmodule

// File: tb/tb_arb_in_fifo.sv
// Scoreboard bench for arb_in_fifo: a queue model of the buffer is compared every cycle.
module tb_arb_in_fifo;

    localparam int WIDTH    = 64;
    localparam int DEPTH    = 4;
    localparam int AFULL_TH = 3;

    logic             CLK;
    logic             ASynReset_N;
    logic             i_Flush;
    logic             i_WrValid;
    logic [WIDTH-1:0] i_WrData;
    logic             o_WrReady;
    logic             o_DataValid;
    logic [WIDTH-1:0] o_DataOut;
    logic             i_DataGrant;
    logic [2:0]       o_Count;
    logic             o_Full;
    logic             o_Empty;
    logic             o_AFull;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    logic [WIDTH-1:0] q[$];
    logic             lastV, lastG, lastF;
    logic [WIDTH-1:0] lastD;

    arb_in_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .CLK         (CLK),
        .ASynReset_N (ASynReset_N),
        .i_Flush     (i_Flush),
        .i_WrValid   (i_WrValid),
        .i_WrData    (i_WrData),
        .o_WrReady   (o_WrReady),
        .o_DataValid (o_DataValid),
        .o_DataOut   (o_DataOut),
        .i_DataGrant (i_DataGrant),
        .o_Count     (o_Count),
        .o_Full      (o_Full),
        .o_Empty     (o_Empty),
        .o_AFull     (o_AFull)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic cmp(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: an ordered list of held words, updated from the inputs seen at each edge.
    task automatic updateModel();
        bit doPop;
        bit doWr;
        if (lastF) begin
            q.delete();
        end else begin
            doPop = lastG && (q.size() > 0);
            doWr  = lastV && (q.size() < DEPTH);
            if (doPop) void'(q.pop_front());
            if (doWr) q.push_back(lastD);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic g, input logic f);
        @(posedge CLK);
        #1;
        updateModel();
        i_WrValid   = v;
        i_WrData    = d;
        i_DataGrant = g;
        i_Flush     = f;
        lastV = v;
        lastD = d;
        lastG = g;
        lastF = f;
    endtask

    task automatic checkOutput();
        int n;
        n = q.size();
        cmp("count",     {61'd0, o_Count}, WIDTH'(n));
        cmp("empty",     {63'd0, o_Empty}, WIDTH'(n == 0));
        cmp("full",      {63'd0, o_Full}, WIDTH'(n == DEPTH));
        cmp("afull",     {63'd0, o_AFull}, WIDTH'(n >= AFULL_TH));
        cmp("wrready",   {63'd0, o_WrReady}, WIDTH'(n < DEPTH));
        cmp("datavalid", {63'd0, o_DataValid}, WIDTH'(n > 0));
        if (n > 0) cmp("headword", o_DataOut, q[0]);
    endtask

    // Monitor: compares DUT outputs against the model half a cycle after each edge.
    always @(negedge CLK) begin
        if (started && ASynReset_N) checkOutput();
    end

    initial begin
        ASynReset_N = 1'b0;
        i_Flush     = 1'b0;
        i_WrValid   = 1'b0;
        i_WrData    = '0;
        i_DataGrant = 1'b0;
        lastV = 0; lastG = 0; lastF = 0; lastD = '0;
        repeat (2) @(posedge CLK);
        #1;
        ASynReset_N = 1'b1;
        started = 1;

        $display("[TB] fill");
        applyStimulus(1, 64'h11, 0, 0);
        applyStimulus(1, 64'h22, 0, 0);
        applyStimulus(1, 64'h33, 0, 0);
        applyStimulus(1, 64'h44, 0, 0);
        applyStimulus(1, 64'h55, 0, 0);
        applyStimulus(1, 64'h55, 0, 0);

        $display("[TB] drain");
        for (int i = 0; i < 4; i++) applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 0);

        $display("[TB] streaming");
        applyStimulus(1, 64'hF0, 0, 0);
        for (int k = 1; k <= 20; k++) applyStimulus(1, WIDTH'(k), 1, 0);
        applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 0);

        $display("[TB] edge events");
        applyStimulus(1, 64'hAA, 1, 0);
        applyStimulus(1, 64'hA1, 0, 0);
        applyStimulus(1, 64'hA2, 0, 0);
        applyStimulus(1, 64'hA3, 0, 0);
        applyStimulus(1, 64'hDD, 1, 0);
        applyStimulus(1, 64'hDD, 0, 0);
        applyStimulus(0, '0, 0, 0);

        $display("[TB] flush");
        applyStimulus(0, '0, 1, 0);
        applyStimulus(1, 64'hBB, 1, 1);
        applyStimulus(1, 64'hCC, 0, 0);
        applyStimulus(1, 64'h12, 0, 0);
        applyStimulus(0, '0, 0, 0);

        $display("[TB] async reset");
        #2;
        ASynReset_N = 1'b0;
        #1;
        cmp("rst_datavalid", {63'd0, o_DataValid}, 64'd0);
        cmp("rst_count",     {61'd0, o_Count}, 64'd0);
        cmp("rst_empty",     {63'd0, o_Empty}, 64'd1);
        cmp("rst_full",      {63'd0, o_Full}, 64'd0);
        cmp("rst_afull",     {63'd0, o_AFull}, 64'd0);
        cmp("rst_wrready",   {63'd0, o_WrReady}, 64'd1);
        cmp("rst_dataout",   o_DataOut, 64'd0);
        q.delete();
        lastV = 0; lastG = 0; lastF = 0; lastD = '0;
        @(posedge CLK);
        #1;
        ASynReset_N = 1'b1;

        $display("[TB] random");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 4) != 0, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
                          ($urandom % 48) == 0);
        end
        for (int i = 0; i < 5; i++) applyStimulus(0, '0, 1, 0);
        applyStimulus(0, '0, 0, 0);
        @(posedge CLK);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
